// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential residue-checked multiplier.
//   state_t   : controller states
//   MOD3_LUT  : (x*y) mod 3 for residues x, y in 0..2
//   mod3()    : mod-3 reduction of a value up to 32 bits wide
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MOD3_LUT [3][3] = '{
        '{2'd0, 2'd0, 2'd0},
        '{2'd0, 2'd1, 2'd2},
        '{2'd0, 2'd2, 2'd1}
    };

    // 4^k == 1 (mod 3), so summing base-4 digits preserves the residue.
    // Three folding rounds bring any 32-bit value down to 0..5.
    function automatic logic [1:0] mod3(input logic [31:0] v);
        logic [5:0] s1;
        logic [3:0] s2;
        logic [2:0] s3;
        s1 = '0;
        for (int i = 0; i < 16; i++) begin
            s1 = s1 + 6'(v[2*i +: 2]);
        end
        s2 = 4'(s1[1:0]) + 4'(s1[3:2]) + 4'(s1[5:4]);
        s3 = 3'(s2[1:0]) + 3'(s2[3:2]);
        if (s3 >= 3'd3) begin
            s3 = s3 - 3'd3;
        end
        return s3[1:0];
    endfunction

endpackage

// File: rtl/mult_seq_resid_mod3.sv
// Combinational W-bit mod-3 reducer.
//   v : value to reduce (W bits)
//   r : v mod 3
// Bit pairs are summed into a narrow accumulator which is then folded by
// the package helper; the sum never exceeds 3*ceil(W/2) <= 96.
module mod3_residue
    import mult_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] v,
    output logic [1:0]   r
);

    localparam int ND = (W + 1) / 2;

    logic [2*ND-1:0] vp;
    logic [7:0]      sum;

    assign vp = (2*ND)'(v);

    always_comb begin
        sum = '0;
        for (int i = 0; i < ND; i++) begin
            sum = sum + 8'(vp[2*i +: 2]);
        end
    end

    assign r = mod3(32'(sum));

endmodule

// File: rtl/mult_seq_resid.sv
// Sequential shift-add unsigned multiplier with mod-3 residue self-check.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a, b)
//   fi_en               : flips product bit 0, only honoured in CHECK
//   out_valid/out_ready : result handshake (p, err)
//   err_cnt             : saturating count of residue mismatches
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// BUSY  | WIDTH shift-add iterations, one multiplier bit per cycle
// CHECK | compare product residue with operand residue product, latch
// DONE  | result held with out_valid high until out_ready
module mult_seq_resid
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               fi_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               err,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);

    state_t         state;
    logic [PW-1:0]  a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]  acc;
    logic [IW-1:0]  iter;
    logic [1:0]     ra;
    logic [1:0]     rb;
    logic [1:0]     ra_in;
    logic [1:0]     rb_in;
    logic [1:0]     rp;
    logic [PW-1:0]  pc;
    logic           mismatch;

    mod3_residue #(.W(WIDTH)) u_res_a (.v(a),  .r(ra_in));
    mod3_residue #(.W(WIDTH)) u_res_b (.v(b),  .r(rb_in));
    mod3_residue #(.W(PW))    u_res_p (.v(pc), .r(rp));

    assign pc       = acc ^ {{(PW-1){1'b0}}, fi_en};
    assign mismatch = (rp != MOD3_LUT[ra][rb]);

    // Decoded from state so it is already high in the first cycle after
    // reset release; masked while reset is held.
    assign in_ready = (state == IDLE) && !rst;

    // a_sh/b_sh shift each iteration, so a_sh always holds a << i and
    // b_sh[0] is multiplier bit i. iter counts down to terminal zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            iter      <= '0;
            ra        <= '0;
            rb        <= '0;
            p         <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= PW'(a);
                        b_sh  <= b;
                        acc   <= '0;
                        iter  <= IW'(WIDTH - 1);
                        ra    <= ra_in;
                        rb    <= rb_in;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (b_sh[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    if (iter == '0) begin
                        state <= CHECK;
                    end else begin
                        iter <= iter - IW'(1);
                    end
                end
                CHECK: begin
                    p   <= pc;
                    err <= mismatch;
                    if (mismatch && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_resid.sv
// Directed bench for mult_seq_resid: three instances (WIDTH=4/CNT_W=8,
// WIDTH=4/CNT_W=2, WIDTH=8/CNT_W=8) share stimulus; sel picks the one
// whose handshakes are driven and whose outputs are observed.
module tb_mult_seq_resid;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       fi_en;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;

    always #5 clk = ~clk;

    logic       in_ready4, out_valid4, err4;
    logic [7:0] p4, cnt4;
    logic       in_ready2, out_valid2, err2;
    logic [7:0] p2;
    logic [1:0] cnt2;
    logic       in_ready8, out_valid8, err8;
    logic [15:0] p8;
    logic [7:0] cnt8;

    mult_seq_resid #(.WIDTH(4), .CNT_W(8)) u_w4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd0), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .fi_en(fi_en),
        .out_valid(out_valid4), .out_ready(out_ready && sel == 2'd0),
        .p(p4), .err(err4), .err_cnt(cnt4)
    );

    mult_seq_resid #(.WIDTH(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd1), .in_ready(in_ready2),
        .a(a[3:0]), .b(b[3:0]), .fi_en(fi_en),
        .out_valid(out_valid2), .out_ready(out_ready && sel == 2'd1),
        .p(p2), .err(err2), .err_cnt(cnt2)
    );

    mult_seq_resid #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2'd2), .in_ready(in_ready8),
        .a(a), .b(b), .fi_en(fi_en),
        .out_valid(out_valid8), .out_ready(out_ready && sel == 2'd2),
        .p(p8), .err(err8), .err_cnt(cnt8)
    );

    logic        in_ready_s, out_valid_s, err_s;
    logic [15:0] p_s;
    logic [7:0]  cnt_s;

    always_comb begin
        in_ready_s  = in_ready4;
        out_valid_s = out_valid4;
        err_s       = err4;
        p_s         = {8'd0, p4};
        cnt_s       = cnt4;
        if (sel == 2'd1) begin
            in_ready_s  = in_ready2;
            out_valid_s = out_valid2;
            err_s       = err2;
            p_s         = {8'd0, p2};
            cnt_s       = {6'd0, cnt2};
        end else if (sel == 2'd2) begin
            in_ready_s  = in_ready8;
            out_valid_s = out_valid8;
            err_s       = err8;
            p_s         = p8;
            cnt_s       = cnt8;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full transaction on the selected instance. fi_chk drives fi_en
    // during the CHECK cycle, fi_oth during every other cycle after accept.
    task automatic do_txn(input logic [7:0] aa, input logic [7:0] bb,
                          input logic fi_chk, input logic fi_oth, input int hold,
                          input logic [15:0] exp_p, input logic exp_err,
                          output logic [7:0] cnt, output int cyc);
        int w;
        int t;
        w = (sel == 2'd2) ? 8 : 4;
        t = 0;
        while (!in_ready_s && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_wait", 32'(in_ready_s), 32'd1);
        a = aa;
        b = bb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5;
        b = 8'h5A;
        cyc = 1;
        while (!out_valid_s && cyc < 100) begin
            fi_en = (cyc == w + 1) ? fi_chk : fi_oth;
            @(posedge clk); #1;
            cyc++;
        end
        fi_en = fi_oth;
        check("out_valid_rise", 32'(out_valid_s), 32'd1);
        check("latency", 32'(cyc), 32'(w + 2));
        check("p", 32'(p_s), 32'(exp_p));
        check("err", 32'(err_s), 32'(exp_err));
        cnt = cnt_s;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_p", 32'(p_s), 32'(exp_p));
            check("hold_err", 32'(err_s), 32'(exp_err));
            check("hold_valid", 32'(out_valid_s), 32'd1);
            check("hold_ready", 32'(in_ready_s), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        fi_en = 1'b0;
        check("ov_drop", 32'(out_valid_s), 32'd0);
        check("in_ready_back", 32'(in_ready_s), 32'd1);
    endtask

    logic [7:0] sat_a [4] = '{8'd3, 8'd15, 8'd2, 8'd9};
    logic [7:0] sat_b [4] = '{8'd5, 8'd15, 8'd7, 8'd9};
    logic [15:0] sat_p [4] = '{16'd14, 16'd224, 16'd15, 16'd80};
    logic [7:0] sat_c [4] = '{8'd1, 8'd2, 8'd3, 8'd3};

    initial begin
        logic [7:0] cnt;
        int cyc;
        logic ov_seen;

        rst = 1'b1;
        in_valid = 1'b0;
        fi_en = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sel = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready_s), 32'd0);
        check("rst_out_valid", 32'(out_valid_s), 32'd0);
        check("rst_p", 32'(p_s), 32'd0);
        check("rst_err", 32'(err_s), 32'd0);
        check("rst_cnt", 32'(cnt_s), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready_s), 32'd1);

        // Basic products, WIDTH=4
        do_txn(8'd15, 8'd15, 1'b0, 1'b0, 0, 16'd225, 1'b0, cnt, cyc);
        check("t1_cnt", 32'(cnt), 32'd0);
        check("t1_cycle", 32'(cyc), 32'd6);
        do_txn(8'd0, 8'd9, 1'b0, 1'b0, 0, 16'd0, 1'b0, cnt, cyc);
        do_txn(8'd7, 8'd0, 1'b0, 1'b0, 0, 16'd0, 1'b0, cnt, cyc);

        // Fault injection in CHECK, then only outside CHECK
        do_txn(8'd15, 8'd15, 1'b1, 1'b0, 0, 16'd224, 1'b1, cnt, cyc);
        check("fi_cnt", 32'(cnt), 32'd1);
        do_txn(8'd15, 8'd15, 1'b0, 1'b1, 2, 16'd225, 1'b0, cnt, cyc);
        check("fi_off_cnt", 32'(cnt), 32'd1);

        // Backpressure for 10 cycles
        do_txn(8'd13, 8'd11, 1'b0, 1'b0, 10, 16'd143, 1'b0, cnt, cyc);

        // Exhaustive 4-bit sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_txn(8'(ia), 8'(ib), 1'b0, 1'b0, 0, 16'(ia * ib), 1'b0, cnt, cyc);
            end
        end
        check("sweep_cnt", 32'(cnt4), 32'd1);

        // Counter saturation, CNT_W=2
        sel = 2'd1;
        for (int i = 0; i < 4; i++) begin
            do_txn(sat_a[i], sat_b[i], 1'b1, 1'b0, 0, sat_p[i], 1'b1, cnt, cyc);
            check("sat_cnt", 32'(cnt), 32'(sat_c[i]));
        end

        // WIDTH=8
        sel = 2'd2;
        do_txn(8'd255, 8'd255, 1'b0, 1'b0, 0, 16'd65025, 1'b0, cnt, cyc);

        // Reset in cycle 2 of a transaction discards it
        a = 8'd200;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready_s), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", 32'(out_valid_s), 32'd0);
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid_s) ov_seen = 1'b1;
        end
        check("discarded", 32'(ov_seen), 32'd0);
        do_txn(8'd200, 8'd3, 1'b0, 1'b0, 0, 16'd600, 1'b0, cnt, cyc);
        check("post_rst_cnt", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
